// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_REQ requesters.
// Optional burst locking is enabled by defining BURST_LOCK_EN.
module mem_port_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RD_LAT  = 2
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                     state_q;
  logic [IdW-1:0]             rr_ptr_q;
  logic [RD_LAT:0]            tag_vld_q;
  logic [RD_LAT:0][IdW-1:0]   tag_id_q;
  logic [NUM_REQ-1:0]         eligible;
  logic                       win_vld;
  logic [IdW-1:0]             win_id;

`ifdef BURST_LOCK_EN
  logic [IdW-1:0]             owner_q;
`else
  logic                       unused_sig;
  assign unused_sig = ^{lock, state_q};
`endif

  always_comb begin
    eligible = req;
`ifdef BURST_LOCK_EN
    if (state_q == StLocked) eligible = req & (NUM_REQ'(1) << owner_q);
`endif
  end

  // Scan from farthest to nearest so the first hit after rr_ptr wins.
  always_comb begin
    int unsigned idx;
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      idx = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (eligible[idx]) begin
        win_vld = 1'b1;
        win_id  = IdW'(idx);
      end
    end
  end

  assign gnt    = (win_vld && sys_rst_n) ? (NUM_REQ'(1) << win_id) : '0;
  assign rvalid = tag_vld_q[RD_LAT] ? (NUM_REQ'(1) << tag_id_q[RD_LAT]) : '0;
  assign rdata  = mem_rdata;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= StIdle;
      rr_ptr_q  <= IdW'(NUM_REQ - 1);
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
`ifdef BURST_LOCK_EN
      owner_q   <= '0;
`endif
    end else begin
      mem_en    <= win_vld;
      mem_we    <= win_vld & we[win_id];
      tag_vld_q <= {tag_vld_q[RD_LAT-1:0], win_vld & ~we[win_id]};
      tag_id_q  <= {tag_id_q[RD_LAT-1:0], win_id};
      if (win_vld) begin
        rr_ptr_q  <= win_id;
        mem_addr  <= addr[ADDR_W*32'(win_id) +: ADDR_W];
        mem_wdata <= wdata[DATA_W*32'(win_id) +: DATA_W];
      end
`ifdef BURST_LOCK_EN
      unique case (state_q)
        StIdle: begin
          if (win_vld && lock[win_id]) begin
            state_q <= StLocked;
            owner_q <= win_id;
          end
        end
        StLocked: begin
          // While locked any grant goes to the owner.
          if ((win_vld || !req[owner_q]) && !lock[owner_q]) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
`endif
    end
  end

endmodule
